mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register for the 5-stage MIPS datapath. Consumes the EX/MEM register outputs and drives a ready/req data-memory port that may take several cycles. It stalls the upstream pipeline while an access is outstanding and registers the write-back bundle for the WB mux and register file.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles in ACCESS before the access is aborted (1..255).
- `clk` in 1: clock. Everything is on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `alu_result` in 32: memory address, or ALU result for non-memory instructions.
- `read_data2` in 32: store data.
- `dest_reg` in 5: destination register number.
- `memRead`, `memWrite`, `MemtoReg`, `RegWrite` in 1 each: control from EX/MEM.
- `ALUop` in 6: operation code. Used only for access size.
- `dmem_ready` in 1: memory completes the current request this cycle.
- `dmem_rdata` in 32: load data. Valid when `dmem_ready`=1.
- `dmem_req` out 1: access request. High for the whole ACCESS state.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: word-aligned address, `{alu_result[31:2],2'b00}`.
- `dmem_wdata` out 32: store data, lane-aligned.
- `dmem_be` out 4: byte enables.
- `stall` out 1: freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- `read_data_out` out 32: MEM/WB load data.
- `alu_result_out` out 32: MEM/WB ALU result.
- `dest_reg_out` out 5: MEM/WB destination register.
- `MemtoReg_out`, `RegWrite_out` out 1 each: MEM/WB control.
- `mem_err` out 1: sticky flag for misalignment or timeout.

## Operation
- **Definitions.**
  - access = `memRead | memWrite`.
  - `memRead` takes priority; if both are set, the access is treated as a read.
- **FSM states:**
  - IDLE:
    - access and aligned → ACCESS.
    - access and misaligned → stay in IDLE, set `mem_err`.
    - no access → stay in IDLE.
  - ACCESS:
    - `dmem_ready` → IDLE.
    - timeout counter == `TIMEOUT_CYCLES`-1 without ready → IDLE, set `mem_err`.
- **stall** = (IDLE & access & aligned) | (ACCESS & !`dmem_ready` & !timeout).
- **MEM/WB register** loads on every edge:
  - Non-access instruction in IDLE: inputs pass through; `read_data_out`=0.
  - ACCESS with `dmem_ready`: `read_data_out` = extracted and extended `dmem_rdata` (reads) or 0 (writes); other fields pass through.
  - Bubble (`RegWrite_out`=0, `MemtoReg_out`=0, `dest_reg_out`=0, data fields 0) loads in all other cases: any stalled cycle, timeout abort, misaligned access.
- **Timeout counter:**
  - 8-bit.
  - Cleared on entry to ACCESS; increments each ACCESS cycle.
- **mem_err:** sticky; cleared only by reset.
- **Reset** (asynchronous, including mid-ACCESS):
  - State returns to IDLE; the counter clears.
  - `dmem_req`=0; all MEM/WB outputs and `mem_err` = 0.
  - The in-flight access is dropped. A memory response arriving after reset is ignored.

## Timing
- Non-memory instruction: MEM/WB valid 1 cycle after EX/MEM; no stall.
- Access presented in cycle 0:
  - `stall`=1 in cycle 0.
  - `dmem_req`=1 from cycle 1.
  - Ready in cycle k≥1 → `stall`=0 in cycle k, and MEM/WB valid after the edge ending cycle k.
  - Minimum latency is 2 cycles.
- `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_be` are held stable throughout ACCESS; they come from the frozen EX/MEM inputs.
- Back-to-back accesses: after completing, IDLE sees the next instruction in the following cycle, so each access costs at least 2 cycles.

## Configuration
- **Macro:** `MEM_SUBWORD_EN`.
- **Defined:**
  - `ALUop` selects the access:
    - loads: LW, LH, LHU, LB, LBU.
    - stores: SW, SH, SB.
  - Byte enables: `dmem_be` = lane mask from `alu_result[1:0]`.
  - Store data is replicated into the byte lanes.
  - Loads are extracted from the lane, then sign- or zero-extended.
  - Misaligned accesses:
    - halfword with addr[0]=1.
    - word with addr[1:0]≠0.
- **Undefined:**
  - All accesses are words; `ALUop` is ignored.
  - `dmem_be`=4'hF; data passes unmodified.
  - Misaligned means addr[1:0]≠0.

## Structure
- **Package `mips_pkg`:**
  - ALUop load/store codes (`ALUOP_LW`, `ALUOP_LH`, `ALUOP_LHU`, `ALUOP_LB`, `ALUOP_LBU`, `ALUOP_SW`, `ALUOP_SH`, `ALUOP_SB`).
  - FSM state encoding `mem_state_t` {IDLE, ACCESS}.
  - Timeout counter width.
- **Sub-module `mem_align`:** combinational.
  - Store side: `be` and `wdata` lane generation.
  - Load side: data extraction and extension.
  - Misalignment detection.
  - Its internals are under `MEM_SUBWORD_EN`.

## Test plan
- **Non-memory pass-through:** ADD, `RegWrite`=1, `alu_result`=0x1234, `dest_reg`=5 → next cycle `alu_result_out`=0x1234, `dest_reg_out`=5, `RegWrite_out`=1; `stall` never asserts.
- **Load with latency:**
  - Stimulus: LW addr 0x100; `dmem_ready` in the 3rd ACCESS cycle with rdata 0xDEADBEEF.
  - Response:
    - `stall` high for 3 cycles.
    - Bubbles in MEM/WB during the stall.
    - Then `read_data_out`=0xDEADBEEF, `MemtoReg_out`=1.
- **Byte store** (`MEM_SUBWORD_EN`): SB addr 0x203, data 0x000000A5 → `dmem_be`=4'b1000, `dmem_wdata`=0xA5A5A5A5, `dmem_we`=1.
- **Signed byte load** (`MEM_SUBWORD_EN`): LB addr 0x201, rdata 0x00008000 → `read_data_out`=0xFFFFFF80; LBU gives 0x00000080.
- **Timeout:**
  - Stimulus: `TIMEOUT_CYCLES`=4; LW with `dmem_ready` never asserted.
  - Response: after 4 ACCESS cycles, `dmem_req` drops, `stall`=0, a bubble is loaded, `mem_err`=1 and stays set.
- **Misaligned access and reset:**
  - LW addr 0x102 → no `dmem_req`, no stall, a bubble is loaded, `mem_err`=1.
  - Separately: reset asserted in the 2nd ACCESS cycle → `dmem_req`=0, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: ALUop memory codes, MEM-stage FSM
// encoding and timeout counter width.
package mips_pkg;

  localparam logic [5:0] ALUOP_LB  = 6'h20;
  localparam logic [5:0] ALUOP_LH  = 6'h21;
  localparam logic [5:0] ALUOP_LW  = 6'h23;
  localparam logic [5:0] ALUOP_LBU = 6'h24;
  localparam logic [5:0] ALUOP_LHU = 6'h25;
  localparam logic [5:0] ALUOP_SB  = 6'h28;
  localparam logic [5:0] ALUOP_SH  = 6'h29;
  localparam logic [5:0] ALUOP_SW  = 6'h2B;

  localparam int TO_CNT_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering for the data-memory port: byte enables, store
// replication, load extraction/extension and misalignment. Sub-word support under MEM_SUBWORD_EN.
import mips_pkg::*;

module mem_align (
  input  logic [5:0]  alu_op,
  input  logic [1:0]  addr_lo,
  input  logic        is_read,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

`ifdef MEM_SUBWORD_EN
  logic        is_byte;
  logic        is_half;
  logic        is_signed;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Load codes only count for reads and store codes only for writes.
  always_comb begin
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_signed = 1'b0;
    if (is_read) begin
      case (alu_op)
        ALUOP_LB:  begin is_byte = 1'b1; is_signed = 1'b1; end
        ALUOP_LBU: is_byte = 1'b1;
        ALUOP_LH:  begin is_half = 1'b1; is_signed = 1'b1; end
        ALUOP_LHU: is_half = 1'b1;
        default:   ;
      endcase
    end else begin
      case (alu_op)
        ALUOP_SB: is_byte = 1'b1;
        ALUOP_SH: is_half = 1'b1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be         = 4'hF;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = |addr_lo;
    if (is_byte) begin
      be         = 4'b0001 << addr_lo;
      wdata      = {4{store_data[7:0]}};
      load_data  = {{24{is_signed & lane_b[7]}}, lane_b};
      misaligned = 1'b0;
    end else if (is_half) begin
      be         = addr_lo[1] ? 4'b1100 : 4'b0011;
      wdata      = {2{store_data[15:0]}};
      load_data  = {{16{is_signed & lane_h[15]}}, lane_h};
      misaligned = addr_lo[0];
    end
  end
`else
  logic unused_sel;

  assign be         = 4'hF;
  assign wdata      = store_data;
  assign load_data  = rdata;
  assign misaligned = |addr_lo;
  assign unused_sel = ^{alu_op, is_read};
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with a multi-cycle ready/req data-memory port, upstream stall, access
// timeout and the MEM/WB register. Optional sub-word accesses with MEM_SUBWORD_EN.
import mips_pkg::*;

module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result,
  input  logic [31:0] read_data2,
  input  logic [4:0]  dest_reg,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [5:0]  ALUop,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        stall,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  dest_reg_out,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic        mem_err
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t          state_reg;
  logic [TO_CNT_W-1:0] cnt_reg;
  logic                access;
  logic                in_access;
  logic                misaligned;
  logic                timeout;
  logic [31:0]         load_data;

  assign access    = memRead | memWrite;
  assign in_access = (state_reg == ACCESS);
  assign timeout   = in_access & ~dmem_ready & (cnt_reg == TO_LAST);
  assign stall     = (~in_access & access & ~misaligned) | (in_access & ~dmem_ready & ~timeout);

  // Port fields come straight from EX/MEM, which the stall keeps frozen during ACCESS.
  assign dmem_req  = in_access;
  assign dmem_we   = memWrite & ~memRead;
  assign dmem_addr = {alu_result[31:2], 2'b00};

  mem_align u_align (
    .alu_op     (ALUop),
    .addr_lo    (alu_result[1:0]),
    .is_read    (memRead),
    .store_data (read_data2),
    .rdata      (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      mem_err        <= 1'b0;
      read_data_out  <= '0;
      alu_result_out <= '0;
      dest_reg_out   <= '0;
      MemtoReg_out   <= 1'b0;
      RegWrite_out   <= 1'b0;
    end else begin
      // A bubble unless one of the branches below retires the instruction.
      read_data_out  <= '0;
      alu_result_out <= '0;
      dest_reg_out   <= '0;
      MemtoReg_out   <= 1'b0;
      RegWrite_out   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!access) begin
            alu_result_out <= alu_result;
            dest_reg_out   <= dest_reg;
            MemtoReg_out   <= MemtoReg;
            RegWrite_out   <= RegWrite;
          end else if (misaligned) begin
            mem_err <= 1'b1;
          end else begin
            state_reg <= ACCESS;
            cnt_reg   <= '0;
          end
        end
        ACCESS: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (dmem_ready) begin
            state_reg      <= IDLE;
            read_data_out  <= memRead ? load_data : 32'h0;
            alu_result_out <= alu_result;
            dest_reg_out   <= dest_reg;
            MemtoReg_out   <= MemtoReg;
            RegWrite_out   <= RegWrite;
          end else if (timeout) begin
            state_reg <= IDLE;
            mem_err   <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (TIMEOUT_CYCLES=4); sub-word cases run when MEM_SUBWORD_EN is defined.
import mips_pkg::*;

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result, read_data2, dmem_rdata;
  logic [4:0]  dest_reg;
  logic        memRead, memWrite, MemtoReg, RegWrite, dmem_ready;
  logic [5:0]  ALUop;
  logic        dmem_req, dmem_we, stall, MemtoReg_out, RegWrite_out, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, read_data_out, alu_result_out;
  logic [3:0]  dmem_be;
  logic [4:0]  dest_reg_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .alu_result(alu_result), .read_data2(read_data2),
    .dest_reg(dest_reg), .memRead(memRead), .memWrite(memWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUop(ALUop), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .stall(stall), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .dest_reg_out(dest_reg_out),
    .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out), .mem_err(mem_err)
  );

  task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] dst);
    memRead = rd; memWrite = wr; MemtoReg = m2r; RegWrite = rw;
    ALUop = op; alu_result = addr; read_data2 = data; dest_reg = dst;
  endtask

  task automatic set_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 5'd0);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", dmem_req); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if ({read_data_out, alu_result_out, dest_reg_out, MemtoReg_out, RegWrite_out} !== 71'h0)
      begin n_err++; $display("FAIL reset_memwb: got %h/%h/%0d/%b/%b want all 0", read_data_out, alu_result_out, dest_reg_out, MemtoReg_out, RegWrite_out); end
    n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", mem_err); end
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 32'h0000_1234, 32'h0, 5'd5);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL pass_stall: got %b want 0", stall); end
    next_edge();
    n_cmp++; if (alu_result_out !== 32'h0000_1234) begin n_err++; $display("FAIL pass_alu: got %h want 00001234", alu_result_out); end
    n_cmp++; if (dest_reg_out !== 5'd5) begin n_err++; $display("FAIL pass_dest: got %0d want 5", dest_reg_out); end
    n_cmp++; if (RegWrite_out !== 1'b1) begin n_err++; $display("FAIL pass_rw: got %b want 1", RegWrite_out); end
    n_cmp++; if (read_data_out !== 32'h0) begin n_err++; $display("FAIL pass_rdata: got %h want 0", read_data_out); end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 32'hCAFE_F00D, 32'h0, 5'd31);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL pass2_stall: got %b want 0", stall); end
    next_edge();
    n_cmp++; if ({alu_result_out, dest_reg_out, MemtoReg_out, RegWrite_out} !== {32'hCAFE_F00D, 5'd31, 1'b1, 1'b0})
      begin n_err++; $display("FAIL pass2_fields: got %h/%0d/%b/%b want cafef00d/31/1/0", alu_result_out, dest_reg_out, MemtoReg_out, RegWrite_out); end
  endtask

  task automatic test_load_latency();
    drive(1'b1, 1'b0, 1'b1, 1'b1, ALUOP_LW, 32'h0000_0100, 32'h0, 5'd8);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL load_stall c%0d: got %b want 1", c, stall); end
      n_cmp++; if (dmem_req !== (c != 0)) begin n_err++; $display("FAIL load_req c%0d: got %b want %b", c, dmem_req, c != 0); end
      next_edge();
      n_cmp++; if ({RegWrite_out, MemtoReg_out, dest_reg_out, read_data_out} !== 39'h0)
        begin n_err++; $display("FAIL load_bubble c%0d: got rw=%b m2r=%b dst=%0d rd=%h want all 0", c, RegWrite_out, MemtoReg_out, dest_reg_out, read_data_out); end
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL load_ready_stall: got %b want 0", stall); end
    n_cmp++; if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, 1'b0, 32'h0000_0100, 4'hF})
      begin n_err++; $display("FAIL load_port: got req=%b we=%b addr=%h be=%h want 1/0/00000100/f", dmem_req, dmem_we, dmem_addr, dmem_be); end
    next_edge();
    set_idle();
    n_cmp++; if (read_data_out !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_data: got %h want deadbeef", read_data_out); end
    n_cmp++; if ({MemtoReg_out, RegWrite_out, dest_reg_out, alu_result_out} !== {1'b1, 1'b1, 5'd8, 32'h0000_0100})
      begin n_err++; $display("FAIL load_ctrl: got m2r=%b rw=%b dst=%0d alu=%h want 1/1/8/00000100", MemtoReg_out, RegWrite_out, dest_reg_out, alu_result_out); end
    @(negedge clk);
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL load_req_drop: got %b want 0", dmem_req); end
    next_edge();
  endtask

  task automatic test_store_word();
    drive(1'b0, 1'b1, 1'b0, 1'b0, ALUOP_SW, 32'h0000_0204, 32'h1122_3344, 5'd0);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL sw_stall0: got %b want 1", stall); end
    next_edge();
    dmem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr} !== {1'b1, 1'b1, 4'hF, 32'h1122_3344, 32'h0000_0204})
      begin n_err++; $display("FAIL sw_port: got req=%b we=%b be=%h wd=%h addr=%h want 1/1/f/11223344/00000204", dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL sw_stall1: got %b want 0", stall); end
    next_edge();
    set_idle();
    n_cmp++; if ({read_data_out, alu_result_out, RegWrite_out} !== {32'h0, 32'h0000_0204, 1'b0})
      begin n_err++; $display("FAIL sw_memwb: got rd=%h alu=%h rw=%b want 0/00000204/0", read_data_out, alu_result_out, RegWrite_out); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd_vals [2];
    rd_vals[0] = 32'h0BAD_CAFE;
    rd_vals[1] = 32'h7654_3210;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, ALUOP_LW, 32'h0000_0400 + 32'(k * 4), 32'h0, 5'(10 + k));
      dmem_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if ({stall, dmem_req} !== 2'b10) begin n_err++; $display("FAIL b2b_issue%0d: got stall=%b req=%b want 1/0", k, stall, dmem_req); end
      next_edge();
      dmem_ready = 1'b1;
      dmem_rdata = rd_vals[k];
      @(negedge clk);
      n_cmp++; if ({stall, dmem_req} !== 2'b01) begin n_err++; $display("FAIL b2b_done%0d: got stall=%b req=%b want 0/1", k, stall, dmem_req); end
      next_edge();
      n_cmp++; if ({read_data_out, dest_reg_out} !== {rd_vals[k], 5'(10 + k)})
        begin n_err++; $display("FAIL b2b_data%0d: got %h/%0d want %h/%0d", k, read_data_out, dest_reg_out, rd_vals[k], 10 + k); end
    end
    set_idle();
    next_edge();
  endtask

`ifdef MEM_SUBWORD_EN
  task automatic test_subword();
    drive(1'b0, 1'b1, 1'b0, 1'b0, ALUOP_SB, 32'h0000_0203, 32'h0000_00A5, 5'd0);
    next_edge();
    dmem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({dmem_be, dmem_wdata, dmem_we} !== {4'b1000, 32'hA5A5_A5A5, 1'b1})
      begin n_err++; $display("FAIL sb_port: got be=%b wd=%h we=%b want 1000/a5a5a5a5/1", dmem_be, dmem_wdata, dmem_we); end
    next_edge();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, (k == 0) ? ALUOP_LB : ALUOP_LBU, 32'h0000_0201, 32'h0, 5'd4);
      dmem_ready = 1'b0;
      next_edge();
      dmem_ready = 1'b1;
      dmem_rdata = 32'h0000_8000;
      next_edge();
      n_cmp++; if (read_data_out !== ((k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080))
        begin n_err++; $display("FAIL lb_ext%0d: got %h want %h", k, read_data_out, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080); end
    end
    set_idle();
    next_edge();
  endtask
`endif

  task automatic test_misaligned();
    n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL mis_err_pre: got %b want 0", mem_err); end
    drive(1'b1, 1'b0, 1'b1, 1'b1, ALUOP_LW, 32'h0000_0102, 32'h0, 5'd3);
    @(negedge clk);
    n_cmp++; if ({stall, dmem_req} !== 2'b00) begin n_err++; $display("FAIL mis_stall_req: got stall=%b req=%b want 0/0", stall, dmem_req); end
    next_edge();
    set_idle();
    n_cmp++; if ({RegWrite_out, MemtoReg_out, dest_reg_out, alu_result_out} !== 39'h0)
      begin n_err++; $display("FAIL mis_bubble: got rw=%b m2r=%b dst=%0d alu=%h want all 0", RegWrite_out, MemtoReg_out, dest_reg_out, alu_result_out); end
    n_cmp++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL mis_err: got %b want 1", mem_err); end
    @(negedge clk);
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL mis_no_req: got %b want 0", dmem_req); end
    next_edge();
  endtask

  task automatic test_reset_mid_access();
    drive(1'b1, 1'b0, 1'b1, 1'b1, ALUOP_LW, 32'h0000_0100, 32'h0, 5'd7);
    next_edge();
    next_edge();
    reset = 1'b1;
    set_idle();
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rst_mid_req: got %b want 0", dmem_req); end
    n_cmp++; if ({read_data_out, alu_result_out, dest_reg_out, MemtoReg_out, RegWrite_out, mem_err} !== 72'h0)
      begin n_err++; $display("FAIL rst_mid_out: got %h/%h/%0d/%b/%b err=%b want all 0", read_data_out, alu_result_out, dest_reg_out, MemtoReg_out, RegWrite_out, mem_err); end
    next_edge();
    reset = 1'b0;
    dmem_ready = 1'b1;
    dmem_rdata = 32'hBAAD_F00D;
    next_edge();
    dmem_ready = 1'b0;
    n_cmp++; if ({dmem_req, read_data_out, MemtoReg_out, RegWrite_out} !== 35'h0)
      begin n_err++; $display("FAIL rst_late_resp: got req=%b rd=%h m2r=%b rw=%b want all 0", dmem_req, read_data_out, MemtoReg_out, RegWrite_out); end
  endtask

  task automatic test_timeout();
    drive(1'b1, 1'b0, 1'b1, 1'b1, ALUOP_LW, 32'h0000_0300, 32'h0, 5'd9);
    next_edge();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++; if ({stall, dmem_req} !== 2'b11) begin n_err++; $display("FAIL to_wait c%0d: got stall=%b req=%b want 1/1", c, stall, dmem_req); end
      next_edge();
    end
    n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL to_err_early: got %b want 0", mem_err); end
    @(negedge clk);
    n_cmp++; if ({stall, dmem_req} !== 2'b01) begin n_err++; $display("FAIL to_abort: got stall=%b req=%b want 0/1", stall, dmem_req); end
    next_edge();
    set_idle();
    n_cmp++; if ({mem_err, RegWrite_out, MemtoReg_out, dest_reg_out} !== {1'b1, 7'h0})
      begin n_err++; $display("FAIL to_bubble_err: got err=%b rw=%b m2r=%b dst=%0d want 1/0/0/0", mem_err, RegWrite_out, MemtoReg_out, dest_reg_out); end
    @(negedge clk);
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL to_req_drop: got %b want 0", dmem_req); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 32'h0000_0055, 32'h0, 5'd2);
    next_edge();
    next_edge();
    n_cmp++; if ({mem_err, alu_result_out} !== {1'b1, 32'h0000_0055})
      begin n_err++; $display("FAIL to_sticky: got err=%b alu=%h want 1/00000055", mem_err, alu_result_out); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    next_edge();
    test_passthrough();
    test_load_latency();
    test_store_word();
    test_back_to_back();
`ifdef MEM_SUBWORD_EN
    test_subword();
`endif
    test_misaligned();
    test_reset_mid_access();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
